// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a WIDTH-bit pattern out LSB first, repeat_n+1 times.
// Define SEQ_TX_PRBS_EN to add a 16-bit LFSR source selectable per run with prbs_sel.
module seq_pattern_tx #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             start,
    input  logic             stop,
    input  logic             prbs_sel,
    output logic             outp,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] bit_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t            state_reg;
    logic [WIDTH-1:0]  pattern_reg;
    logic [WIDTH-1:0]  shreg_reg;
    logic [CNT_W-1:0]  rep_cnt_reg;
    logic [IDX_W-1:0]  bit_idx_reg;
    logic              outp_reg;
    logic              valid_reg;
    logic              busy_reg;
    logic              done_reg;

    logic [WIDTH-1:0]  start_src;
    logic              start_go;
    logic              last_bit;
    logic              send_go;
    logic              pat_bit;
    logic              tx_bit;

    assign start_src = load ? data_in : pattern_reg;
    assign start_go  = (state_reg == IDLE) && start;
    assign last_bit  = (bit_idx_reg == LAST_IDX);
    // A bit is emitted on every SEND edge except an abort or the end of the final pass
    assign send_go   = (state_reg == SEND) && !stop && (!last_bit || (rep_cnt_reg != '0));

    always_comb begin
        pat_bit = shreg_reg[0];
        if (state_reg == IDLE)
            pat_bit = start_src[0];
        else if (last_bit)
            pat_bit = pattern_reg[0];
    end

`ifdef SEQ_TX_PRBS_EN
    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;
    logic        prbs_active_reg;
    logic        prbs_now;

    // Fibonacci taps 16,14,13,11; output is bit 0, feedback enters at bit 15
    assign lfsr_next = {lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5], lfsr_reg[15:1]};
    assign prbs_now  = start_go ? prbs_sel : prbs_active_reg;
    assign tx_bit    = prbs_now ? lfsr_reg[0] : pat_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg        <= 16'hACE1;
            prbs_active_reg <= 1'b0;
        end else begin
            if (start_go)
                prbs_active_reg <= prbs_sel;
            if ((start_go || send_go) && prbs_now)
                lfsr_reg <= lfsr_next;
        end
    end
`else
    logic unused_prbs_sel;
    assign unused_prbs_sel = prbs_sel;
    assign tx_bit          = pat_bit;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            pattern_reg <= '0;
            shreg_reg   <= '0;
            rep_cnt_reg <= '0;
            bit_idx_reg <= '0;
            outp_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load)
                        pattern_reg <= data_in;
                    if (start) begin
                        outp_reg    <= tx_bit;
                        shreg_reg   <= start_src >> 1;
                        bit_idx_reg <= '0;
                        rep_cnt_reg <= repeat_n;
                        valid_reg   <= 1'b1;
                        busy_reg    <= 1'b1;
                        state_reg   <= SEND;
                    end
                end
                SEND: begin
                    if (stop) begin
                        outp_reg    <= 1'b0;
                        valid_reg   <= 1'b0;
                        busy_reg    <= 1'b0;
                        bit_idx_reg <= '0;
                        state_reg   <= IDLE;
                    end else if (!last_bit) begin
                        outp_reg    <= tx_bit;
                        shreg_reg   <= shreg_reg >> 1;
                        bit_idx_reg <= bit_idx_reg + 1'b1;
                    end else if (rep_cnt_reg != '0) begin
                        // Back-to-back repetition: no idle cycle between passes
                        outp_reg    <= tx_bit;
                        shreg_reg   <= pattern_reg >> 1;
                        bit_idx_reg <= '0;
                        rep_cnt_reg <= rep_cnt_reg - 1'b1;
                    end else begin
                        outp_reg    <= 1'b0;
                        valid_reg   <= 1'b0;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        state_reg   <= DONE;
                    end
                end
                DONE: begin
                    if (load)
                        pattern_reg <= data_in;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign outp    = outp_reg;
    assign valid   = valid_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign bit_idx = bit_idx_reg;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: stimulus queues expected bits, a monitor checks each valid cycle.
module tb_seq_pattern_tx;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [CNT_W-1:0] repeat_n = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             prbs_sel = 1'b0;
    logic             outp;
    logic             valid;
    logic             busy;
    logic             done;
    logic [3:0]       bit_idx;

    typedef struct {
        logic       b;
        logic [3:0] idx;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] lfsr_model = 16'hACE1;

    seq_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .repeat_n(repeat_n),
        .start(start), .stop(stop), .prbs_sel(prbs_sel), .outp(outp), .valid(valid),
        .busy(busy), .done(done), .bit_idx(bit_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every valid cycle consumes one scoreboard entry
    initial begin
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: got outp=%0b idx=%0d, expected no valid at %0t", outp, bit_idx, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("outp", 32'(outp), 32'(e.b));
                    check("bit_idx", 32'(bit_idx), 32'(e.idx));
                    check("busy_while_valid", 32'(busy), 32'd1);
                    $display("[TB] bit idx=%0d outp=%0b", bit_idx, outp);
                end
            end
        end
    end

    task automatic push_bits(input logic [15:0] p, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.b   = p[i % 16];
            e.idx = 4'(i % 16);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_prbs(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.b        = lfsr_model[0];
            e.idx      = 4'(i % 16);
            lfsr_model = {lfsr_model[0] ^ lfsr_model[2] ^ lfsr_model[3] ^ lfsr_model[5], lfsr_model[15:1]};
            exp_q.push_back(e);
        end
    endtask

    task automatic start_run(input logic [15:0] d, input logic ld, input logic [3:0] rn, input logic ps);
        @(posedge clk); #1;
        start = 1'b1; load = ld; data_in = d; repeat_n = rn; prbs_sel = ps;
        @(posedge clk); #1;
        start = 1'b0; load = 1'b0; prbs_sel = 1'b0;
    endtask

    // Returns on the negedge where done is seen (or after the cycle budget)
    task automatic wait_done(input int exp_len, input string name);
        int n = 0;
        bit seen = 0, gap = 0, got = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1;
                break;
            end
            if (valid === 1'b1) begin
                n++;
                if (seen && gap) gap = 1;
                seen = 1;
            end else if (seen) begin
                gap = 1;
            end
        end
        check({name, "_done_seen"}, 32'(got), 32'd1);
        check({name, "_valid_len"}, 32'(n), 32'(exp_len));
        check({name, "_valid_gap"}, 32'(gap), 32'd0);
        check({name, "_valid_at_done"}, 32'(valid), 32'd0);
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        $display("[TB] %s: %0d valid cycles, done=%0b", name, n, got);
    endtask

    task automatic after_done(input string name);
        @(negedge clk);
        check({name, "_done_one_cycle"}, 32'(done), 32'd0);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int t1_bits[16] = '{0,1,0,0,1,1,1,0,1,1,1,0,1,0,1,0};
        bit found;
        bit saw_done;
        exp_t e;

        // Reset state
        #1;
        check("rst_outp", 32'(outp), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bit_idx", 32'(bit_idx), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // T1: load then start, single pass with hand-listed bit order
        @(posedge clk); #1;
        load = 1'b1; data_in = 16'b0101011101110010;
        @(posedge clk); #1;
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e.b = 1'(t1_bits[i]);
            e.idx = 4'(i);
            exp_q.push_back(e);
        end
        start_run(16'h0000, 1'b0, 4'd0, 1'b0);
        wait_done(16, "t1");
        start = 1'b1;  // start during DONE must be ignored
        @(posedge clk); #1;
        start = 1'b0;
        check("t1_start_in_done_busy", 32'(busy), 32'd0);
        check("t1_start_in_done_valid", 32'(valid), 32'd0);
        check("t1_done_one_cycle", 32'(done), 32'd0);

        // T2: three passes, no gap at the wrap
        push_bits(16'h5772, 48);
        start_run(16'h0000, 1'b0, 4'd2, 1'b0);
        wait_done(48, "t2");
        after_done("t2");

        // Max repeat count must not wrap
        push_bits(16'h5772, 256);
        start_run(16'h0000, 1'b0, 4'd15, 1'b0);
        wait_done(256, "rep_max");
        after_done("rep_max");

        // T3: load with start; load during SEND ignored; pattern persists
        push_bits(16'hFFFF, 16);
        start_run(16'hFFFF, 1'b1, 4'd0, 1'b0);
        fork
            begin
                repeat (4) @(posedge clk);
                #1;
                load = 1'b1; data_in = 16'h0000;
                @(posedge clk); #1;
                load = 1'b0;
            end
            wait_done(16, "t3a");
        join
        after_done("t3a");
        push_bits(16'hFFFF, 16);
        start_run(16'h0000, 1'b0, 4'd0, 1'b0);
        wait_done(16, "t3b");
        after_done("t3b");

        // T4: stop at bit_idx 5
        @(posedge clk); #1;
        load = 1'b1; data_in = 16'h5772;
        @(posedge clk); #1;
        load = 1'b0;
        push_bits(16'h5772, 6);
        start_run(16'h0000, 1'b0, 4'd3, 1'b0);
        found = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (valid === 1'b1 && bit_idx == 4'd5) begin
                found = 1;
                break;
            end
        end
        check("t4_reached_idx5", 32'(found), 32'd1);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check("t4_stop_valid", 32'(valid), 32'd0);
        check("t4_stop_busy", 32'(busy), 32'd0);
        check("t4_stop_outp", 32'(outp), 32'd0);
        check("t4_stop_bit_idx", 32'(bit_idx), 32'd0);
        saw_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1;
        end
        check("t4_no_done", 32'(saw_done), 32'd0);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);
        push_bits(16'h5772, 16);
        start_run(16'h0000, 1'b0, 4'd0, 1'b0);
        wait_done(16, "t4_replay");
        after_done("t4_replay");

        // T5: asynchronous reset mid-run at bit_idx 9
        push_bits(16'h5772, 10);
        start_run(16'h0000, 1'b0, 4'd0, 1'b0);
        found = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (valid === 1'b1 && bit_idx == 4'd9) begin
                found = 1;
                break;
            end
        end
        check("t5_reached_idx9", 32'(found), 32'd1);
        #2;
        rst = 1'b1;
        lfsr_model = 16'hACE1;
        #1;
        check("t5_async_outp", 32'(outp), 32'd0);
        check("t5_async_valid", 32'(valid), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        check("t5_async_done", 32'(done), 32'd0);
        check("t5_async_bit_idx", 32'(bit_idx), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        push_bits(16'h0000, 16);
        start_run(16'h0000, 1'b0, 4'd0, 1'b0);
        wait_done(16, "t5_cleared");
        after_done("t5_cleared");

`ifdef SEQ_TX_PRBS_EN
        // T6: PRBS runs continue the LFSR sequence across runs
        push_prbs(16);
        start_run(16'h0000, 1'b0, 4'd0, 1'b1);
        wait_done(16, "t6a");
        after_done("t6a");
        push_prbs(32);
        start_run(16'h0000, 1'b0, 4'd1, 1'b1);
        wait_done(32, "t6b");
        after_done("t6b");
`endif

        repeat (2) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial bit-pattern transmitter; the driving end of the serial single-bit stream consumed by the lab sequence detectors (clk, rst, inp, outp style).
- Holds a WIDTH-bit pattern and shifts it out LSB first, one bit per clock, repeated repeat_n+1 times.
- Start/busy/done handshake.
- Optional PRBS mode replaces the stored pattern with pseudo-random bits for soak testing the detectors.

Parameters:
WIDTH, 16, pattern length in bits (>=2)
CNT_W, 4, width of repeat count

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
load  input  1  capture data_in into pattern register (ignored while busy)
data_in  input  WIDTH  pattern to transmit, bit 0 sent first
repeat_n  input  CNT_W  extra repetitions, sampled with start; total bits = WIDTH*(repeat_n+1)
start  input  1  begin transmission (ignored while busy)
stop  input  1  abort transmission
prbs_sel  input  1  select PRBS source (only with SEQ_TX_PRBS_EN; else ignored)
outp  output  1  serial bit, registered
valid  output  1  outp carries a pattern bit this cycle
busy  output  1  high in SEND state
done  output  1  one-cycle pulse after last bit of a completed run
bit_idx  output  log2(WIDTH)  index of bit currently on outp

Behaviour:
- Clock/reset: single clock clk. Reset rst is asynchronous and active-high.
- Reset values: outp=0, valid=0, busy=0, done=0, bit_idx=0. Pattern reg, shift reg, and repeat counter all cleared. State=IDLE.
- States:
  - IDLE: waiting; accepts load and start.
  - SEND: shifting.
  - DONE: one cycle, done=1, then IDLE.
- Load:
  - In IDLE or DONE, load=1 at an edge writes pattern reg <= data_in.
  - Load in SEND is ignored; the current run is unaffected.
- Start acceptance: start=1 at an edge in IDLE. If load is also high that edge, the new data_in is used. At that edge:
  - outp<=source[0], shreg<=source>>1, bit_idx<=0.
  - rep_cnt<=repeat_n, valid<=1, busy<=1, state SEND.
- Latency: first bit appears on outp the cycle after the start edge.
- Each edge in SEND with bit_idx<WIDTH-1: outp<=shreg[0], shreg shifts right, bit_idx+1.
- Each edge in SEND with bit_idx==WIDTH-1:
  - rep_cnt!=0: reload shreg from pattern reg, outp<=pattern[0], bit_idx<=0, rep_cnt-1, no gap cycle.
  - rep_cnt==0: valid<=0, busy<=0, outp<=0, done<=1, state DONE.
- valid is high for exactly WIDTH*(repeat_n+1) consecutive cycles.
- done is high exactly one cycle. DONE -> IDLE unconditionally. start in DONE is ignored.
- stop=1 at any edge in SEND: valid<=0, busy<=0, outp<=0, bit_idx<=0, state IDLE, done stays 0. stop has priority over the shift and over the final-bit transition. stop outside SEND has no effect.
- Pattern reg persists across runs: a second start without load resends the same pattern.
- Reset mid-run: all outputs drop immediately (asynchronously) to reset values. No done.
- repeat_n=0 gives a single pass. The maximum 2^CNT_W-1 must count correctly with no wrap.

Optional Feature:
- Macro: SEQ_TX_PRBS_EN.
- Defined:
  - Adds 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset.
  - If prbs_sel=1 when start is accepted, outp takes the LFSR output bit each SEND cycle instead of shreg, and the LFSR advances once per valid cycle.
  - Run length, valid, done, bit_idx, and stop behaviour are identical.
  - LFSR state persists across runs and is not reseeded by start.
- Undefined: no LFSR logic; prbs_sel is unused; behaviour is pattern-only.

Test Plan:
1. Reset, load 16'b0101011101110010, start with repeat_n=0 -> outp over 16 valid cycles = 0,1,0,0,1,1,1,0,1,1,1,0,1,0,1,0. Then done=1 for one cycle, then busy=0.
2. Same pattern, repeat_n=2 -> valid high 48 consecutive cycles, bit_idx wraps 15->0 with no gap, single done pulse after cycle 48.
3. start with load same edge in IDLE, data_in=16'hFFFF -> 16 ones; load=1 with data_in=16'h0000 mid-run has no effect; a second start resends 16'hFFFF.
4. stop asserted at bit_idx=5 -> next cycle valid=0, busy=0, outp=0, done never asserts; a subsequent start replays from bit 0.
5. rst asserted at bit_idx=9 between clock edges -> outputs go to reset values before the next edge. After release, start resends pattern 0 (pattern reg cleared).
6. With SEQ_TX_PRBS_EN, prbs_sel=1, repeat_n=0 -> 16 valid bits matching the reference LFSR model from seed 16'hACE1; a second run continues the LFSR sequence without reseeding.
